mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words of storage (power of two).
REQ-002 The block SHALL have parameter LATENCY, default 1, legal 1..15, meaning the number of cycles from acceptance to response.
REQ-003 The block SHALL have port clock, input, 1, the single clock.
REQ-004 The block SHALL have port reset, input, 1, the asynchronous active-high reset.
REQ-005 The block SHALL have port i_req, input, 1, the instruction fetch request.
REQ-006 The block SHALL have port i_addr, input, 32, the fetch byte address (the pc).
REQ-007 The block SHALL have port i_datain, output, 32, the instruction word to the CPU.
REQ-008 The block SHALL have port i_valid, output, 1, a one-cycle pulse marking i_datain valid.
REQ-009 The block SHALL have port d_req, input, 1, the data load/store request.
REQ-010 The block SHALL have port d_we, input, 1, where 1 means store and 0 means load.
REQ-011 The block SHALL have port d_addr, input, 32, the data byte address.
REQ-012 The block SHALL have port d_dataout, input, 32, the store data from the CPU.
REQ-013 The block SHALL have port d_datain, output, 32, the load data to the CPU.
REQ-014 The block SHALL have port d_valid, output, 1, a one-cycle pulse marking d_datain valid or the store done.
REQ-015 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-016 The block SHALL have port err, output, 1, a misaligned-access flag that pulses with the matching valid.
REQ-017 The block SHALL have ports init_we (input, 1), init_addr (input, log2(DEPTH), word index) and init_data (input, 32), forming the preload port.

Function
REQ-018 The block SHALL implement FSM states IDLE, WAIT and RESP, with transitions IDLE->WAIT (LATENCY>1) or IDLE->RESP (LATENCY=1) on acceptance, WAIT->RESP when the counter expires, and RESP->IDLE always.
REQ-019 The block SHALL accept a request only in IDLE; d_req SHALL have priority over i_req when both are high; an unaccepted request SHALL NOT be queued, so the requester holds req until it sees valid.
REQ-020 At acceptance the block SHALL latch the port, address, d_we and d_dataout; input changes after acceptance SHALL have no effect.
REQ-021 Word index SHALL equal addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-022 A load or fetch SHALL read the array at the acceptance edge; a store SHALL write the array at the acceptance edge, so ordering follows acceptance order.
REQ-023 For a request accepted at edge E, the matching valid SHALL be high for exactly the cycle following edge E+LATENCY, with its data registered and stable in that cycle.
REQ-024 For a store response, d_datain SHALL be 0.
REQ-025 Outside a valid cycle, i_datain and d_datain SHALL hold their last value.
REQ-026 When addr[1:0]!=0, the block SHALL suppress the write, return data 0 and assert err together with valid.
REQ-027 A preload write SHALL occur on any edge where init_we=1; if it targets the same word as a store accepted on the same edge, the store SHALL win.
REQ-028 A request held high through the RESP cycle SHALL be accepted in the following IDLE cycle, giving a back-to-back throughput of one access per LATENCY+1 cycles.

Reset
REQ-029 While reset is high, state SHALL be IDLE and i_datain, d_datain, i_valid, d_valid, busy, err and the latency counter SHALL all be 0.
REQ-030 A reset mid-access SHALL abort the access with no valid issued; a store already accepted SHALL remain committed.
REQ-031 Array contents SHALL NOT be cleared by reset.

Structure
REQ-032 Shared package mem_pkg SHALL hold the state enum, the DEPTH/LATENCY defaults and the word-width constant.
REQ-033 Storage SHALL be one sub-module mem_array: 1 read/write port plus 1 write port, synchronous write, with the store write prioritised over the preload write.

Verification
REQ-034 Preload word1=0x000000ab and word2=0x00003c00 with LATENCY=1; d_req load from 0x4 -> d_valid one cycle after acceptance with d_datain=0x000000ab; load from 0x8 -> 0x00003c00.
REQ-035 Raise i_req and d_req in the same cycle with i_addr=0x0 and d_addr=0x4 -> the data load is served first, then the fetch is accepted in the IDLE cycle after RESP; busy is high throughout.
REQ-036 With LATENCY=4, store 0x000000ab+0x00003c00=0x00003cab to 0xC, then load 0xC -> each valid comes 4 cycles after acceptance; the store gives d_datain=0 and the load returns 0x00003cab.
REQ-037 Load from 0x6 -> err and d_valid pulse together with d_datain=0; store to 0x5 -> err pulses and word1 is unchanged.
REQ-038 With LATENCY=4, assert reset 2 cycles after accepting a load -> no valid is issued, all outputs are 0 and the preloaded data survives.
REQ-039 Access address 0x104 with DEPTH=64 -> the access aliases word 1 and returns 0x000000ab.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder memory model.
// Holds the controller state enum, the parameter defaults and the data word width.
package mem_pkg;
  localparam int WORD_W      = 32;
  localparam int DEPTH_DEF   = 64;
  localparam int LATENCY_DEF = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/mem_array.sv
// Word storage: one read/write port driven by accepted requests, plus a preload write port.
// A store and a preload hitting the same word on the same edge resolve in favour of the store.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              rw_en,
  input  logic              rw_we,
  input  logic [AW-1:0]     rw_addr,
  input  logic [WORD_W-1:0] rw_wdata,
  output logic [WORD_W-1:0] rw_rdata,
  input  logic              init_we,
  input  logic [AW-1:0]     init_addr,
  input  logic [WORD_W-1:0] init_data
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  logic store_hit;
  assign store_hit = rw_en && rw_we && (rw_addr == init_addr);

  // No reset here: contents must survive a reset of the controller.
  always_ff @(posedge clock) begin
    if (init_we && !store_hit) mem_q[init_addr] <= init_data;
    if (rw_en && rw_we)        mem_q[rw_addr]   <= rw_wdata;
    if (rw_en && !rw_we)       rdata_q          <= mem_q[rw_addr];
  end

  assign rw_rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder for a CPU's fetch and data ports, with a fixed response latency.
// The array is read or written on the acceptance edge; the response is registered LATENCY edges later.
module mem_responder
  import mem_pkg::*;
#(
  parameter  int DEPTH   = DEPTH_DEF,
  parameter  int LATENCY = LATENCY_DEF,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [WORD_W-1:0] i_datain,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [WORD_W-1:0] d_dataout,
  output logic [WORD_W-1:0] d_datain,
  output logic              d_valid,
  output logic              busy,
  output logic              err,
  input  logic              init_we,
  input  logic [AW-1:0]     init_addr,
  input  logic [WORD_W-1:0] init_data
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              is_d_q, is_d_d;
  logic              we_q, we_d;
  logic              mis_q, mis_d;
  logic [WORD_W-1:0] i_datain_q, i_datain_d;
  logic [WORD_W-1:0] d_datain_q, d_datain_d;
  logic              i_valid_q, i_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              err_q, err_d;

  logic              accept;
  logic [AW-1:0]     acc_word;
  logic              store_en;
  logic [WORD_W-1:0] rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:AW+2], d_addr[31:AW+2]};

  assign acc_word = d_req ? d_addr[AW+1:2] : i_addr[AW+1:2];
  assign store_en = accept && d_req && d_we && (d_addr[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_d_d     = is_d_q;
    we_d       = we_q;
    mis_d      = mis_q;
    i_datain_d = i_datain_q;
    d_datain_d = d_datain_q;
    i_valid_d  = 1'b0;
    d_valid_d  = 1'b0;
    err_d      = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          accept = 1'b1;
          is_d_d = d_req;
          we_d   = d_req && d_we;
          mis_d  = d_req ? (d_addr[1:0] != 2'b00) : (i_addr[1:0] != 2'b00);
          if (LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 2);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        state_d = IDLE;
        err_d   = mis_q;
        if (is_d_q) begin
          d_valid_d  = 1'b1;
          d_datain_d = (we_q || mis_q) ? '0 : rdata;
        end else begin
          i_valid_d  = 1'b1;
          i_datain_d = mis_q ? '0 : rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      is_d_q     <= 1'b0;
      we_q       <= 1'b0;
      mis_q      <= 1'b0;
      i_datain_q <= '0;
      d_datain_q <= '0;
      i_valid_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_d_q     <= is_d_d;
      we_q       <= we_d;
      mis_q      <= mis_d;
      i_datain_q <= i_datain_d;
      d_datain_q <= d_datain_d;
      i_valid_q  <= i_valid_d;
      d_valid_q  <= d_valid_d;
      err_q      <= err_d;
    end
  end

  mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clock     (clock),
    .rw_en     (accept),
    .rw_we     (store_en),
    .rw_addr   (acc_word),
    .rw_wdata  (d_dataout),
    .rw_rdata  (rdata),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  // The valid cycle counts as busy so back-to-back accesses show no gap.
  assign busy     = (state_q != IDLE) || i_valid_q || d_valid_q;
  assign i_datain = i_datain_q;
  assign d_datain = d_datain_q;
  assign i_valid  = i_valid_q;
  assign d_valid  = d_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=1 and one at LATENCY=4 share stimulus,
// with the request gated to the instance selected by sel.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        sel;
  logic        i_req, d_req, d_we, init_we;
  logic [31:0] i_addr, d_addr, d_dataout, init_data;
  logic [5:0]  init_addr;

  logic [31:0] i_dat1, d_dat1, i_dat4, d_dat4;
  logic        i_v1, d_v1, busy1, err1, i_v4, d_v4, busy4, err4;

  logic [31:0] o_i_dat, o_d_dat;
  logic        o_i_v, o_d_v, o_busy, o_err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_responder #(.DEPTH(64), .LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset),
    .i_req(i_req && !sel), .i_addr(i_addr), .i_datain(i_dat1), .i_valid(i_v1),
    .d_req(d_req && !sel), .d_we(d_we), .d_addr(d_addr), .d_dataout(d_dataout),
    .d_datain(d_dat1), .d_valid(d_v1), .busy(busy1), .err(err1),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  mem_responder #(.DEPTH(64), .LATENCY(4)) u_l4 (
    .clock(clock), .reset(reset),
    .i_req(i_req && sel), .i_addr(i_addr), .i_datain(i_dat4), .i_valid(i_v4),
    .d_req(d_req && sel), .d_we(d_we), .d_addr(d_addr), .d_dataout(d_dataout),
    .d_datain(d_dat4), .d_valid(d_v4), .busy(busy4), .err(err4),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  assign o_i_dat = sel ? i_dat4 : i_dat1;
  assign o_d_dat = sel ? d_dat4 : d_dat1;
  assign o_i_v   = sel ? i_v4   : i_v1;
  assign o_d_v   = sel ? d_v4   : d_v1;
  assign o_busy  = sel ? busy4  : busy1;
  assign o_err   = sel ? err4   : err1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clock);
    init_we = 1'b1; init_addr = idx; init_data = val;
    @(negedge clock);
    init_we = 1'b0;
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_idat"}, o_i_dat, 32'h0);
    chk({tag, "_ddat"}, o_d_dat, 32'h0);
    chk({tag, "_iv"},   {31'h0, o_i_v},  32'h0);
    chk({tag, "_dv"},   {31'h0, o_d_v},  32'h0);
    chk({tag, "_busy"}, {31'h0, o_busy}, 32'h0);
    chk({tag, "_err"},  {31'h0, o_err},  32'h0);
  endtask

  // One access on the selected instance; the selected instance must be idle on entry.
  task automatic access(input bit s, input bit isd, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_data, input bit exp_err,
                        input int exp_lat, input bit coll, input string tag);
    int  n;
    bit  seen;
    logic [31:0] dat;
    @(negedge clock);
    sel = s;
    if (isd) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_dataout = wd;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    if (coll) begin
      init_we = 1'b1; init_addr = addr[7:2]; init_data = 32'h6666_6666;
    end
    @(posedge clock);
    #1;
    init_we = 1'b0;
    d_addr = ~addr; d_dataout = ~wd; i_addr = ~addr; d_we = ~we;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clock);
      n++;
      seen = isd ? o_d_v : o_i_v;
    end
    dat = isd ? o_d_dat : o_i_dat;
    chk({tag, "_lat"},  32'(n - 1), 32'(exp_lat));
    chk({tag, "_data"}, dat, exp_data);
    chk({tag, "_err"},  {31'h0, o_err}, {31'h0, exp_err});
    chk({tag, "_othv"}, {31'h0, (isd ? o_i_v : o_d_v)}, 32'h0);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clock);
    chk({tag, "_pulse"}, {31'h0, (isd ? o_d_v : o_i_v)}, 32'h0);
    chk({tag, "_hold"},  (isd ? o_d_dat : o_i_dat), exp_data);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; init_we = 1'b0;
    i_addr = '0; d_addr = '0; d_dataout = '0; init_addr = '0; init_data = '0;
    repeat (3) @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      outputs_zero(s == 0 ? "rst_l1" : "rst_l4");
    end
    @(negedge clock);
    reset = 1'b0;

    preload(6'd0, 32'h1234_5678);
    preload(6'd1, 32'h0000_00ab);
    preload(6'd2, 32'h0000_3c00);

    // Basic loads and a fetch at LATENCY=1
    access(0, 1, 0, 32'h4,   '0, 32'h0000_00ab, 0, 1, 0, "ld4");
    access(0, 1, 0, 32'h8,   '0, 32'h0000_3c00, 0, 1, 0, "ld8");
    access(0, 0, 0, 32'h0,   '0, 32'h1234_5678, 0, 1, 0, "fetch0");
    access(0, 1, 0, 32'h104, '0, 32'h0000_00ab, 0, 1, 0, "alias104");

    // Simultaneous requests: data first, then the fetch after the RESP cycle
    @(negedge clock);
    sel = 1'b0;
    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
    @(posedge clock);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk($sformatf("prio_busy%0d", k), {31'h0, o_busy}, 32'h1);
      chk($sformatf("prio_dv%0d", k), {31'h0, o_d_v}, {31'h0, (k == 2)});
      chk($sformatf("prio_iv%0d", k), {31'h0, o_i_v}, {31'h0, (k == 4)});
      if (k == 2) begin
        chk("prio_ddat", o_d_dat, 32'h0000_00ab);
        d_req = 1'b0;
      end
      if (k == 4) begin
        chk("prio_idat", o_i_dat, 32'h1234_5678);
        i_req = 1'b0;
      end
    end
    repeat (2) @(negedge clock);

    // Misaligned accesses at LATENCY=1
    access(0, 1, 0, 32'h6, '0,           32'h0,         1, 1, 0, "mis_ld6");
    access(0, 1, 1, 32'h5, 32'hdead_beef, 32'h0,        1, 1, 0, "mis_st5");
    access(0, 1, 0, 32'h4, '0,           32'h0000_00ab, 0, 1, 0, "w1_kept");

    // Store and preload on the same edge to the same word
    access(0, 1, 1, 32'h14, 32'h0000_0055, 32'h0,         0, 1, 1, "coll_st");
    access(0, 1, 0, 32'h14, '0,            32'h0000_0055, 0, 1, 0, "coll_ld");

    // LATENCY=4 store then load
    access(1, 1, 1, 32'hC, 32'h0000_00ab + 32'h0000_3c00, 32'h0,         0, 4, 0, "l4_st");
    access(1, 1, 0, 32'hC, '0,                            32'h0000_3cab, 0, 4, 0, "l4_ld");
    access(1, 0, 0, 32'h8, '0,                            32'h0000_3c00, 0, 4, 0, "l4_fetch");

    // Reset two cycles into a LATENCY=4 load
    begin
      int vcount;
      @(negedge clock);
      sel = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
      @(posedge clock);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1; d_req = 1'b0;
      #1;
      outputs_zero("midrst");
      vcount = 0;
      repeat (2) begin
        @(negedge clock);
        vcount += int'(o_d_v) + int'(o_i_v);
      end
      reset = 1'b0;
      repeat (8) begin
        @(negedge clock);
        vcount += int'(o_d_v) + int'(o_i_v);
      end
      chk("midrst_novalid", 32'(vcount), 32'h0);
      chk("midrst_busy", {31'h0, o_busy}, 32'h0);
    end
    access(1, 1, 0, 32'h8, '0, 32'h0000_3c00, 0, 4, 0, "survive_l4");
    access(0, 1, 0, 32'h4, '0, 32'h0000_00ab, 0, 1, 0, "survive_l1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
